// File: rtl/mult_matrix_skew.sv
// mult_matrix_skew
//   Per-lane diagonal delay line sitting in front of (skew) or behind (deskew)
//   a systolic multiplier array. One matrix row is accepted per handshake beat;
//   lane j is delayed by j cycles (skew) or SIZE-1-j cycles (deskew). Bubbles are
//   zero-padded, and the block drains itself after the last row of a frame.
//
// Ports
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   en             : advance enable; when low, all state and outputs hold
//   in_valid       : in_row carries a valid row
//   in_ready       : row can be accepted this cycle (en and not draining)
//   in_last        : accepted row is the final row of the frame
//   mode           : 0 = skew, 1 = deskew; captured on the first row of a frame
//   in_row         : SIZE elements of DATA_SIZE bits, element 0 at the MSB
//   out_row        : lane outputs, packed like in_row
//   out_lane_valid : bit j set when lane j carries a real element
//   out_last       : final element of the frame is on out_row this cycle
//   busy           : a frame is in progress (state not IDLE)
module mult_matrix_skew #(
  parameter int DATA_SIZE = 4,
  parameter int SIZE      = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic                      mode,
  input  logic [DATA_SIZE*SIZE-1:0] in_row,
  output logic [DATA_SIZE*SIZE-1:0] out_row,
  output logic [SIZE-1:0]           out_lane_valid,
  output logic                      out_last,
  output logic                      busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // Drain counter must hold SIZE-2; keep at least one bit for tiny SIZE.
  localparam int CNT_W = (SIZE > 2) ? $clog2(SIZE - 1) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'((SIZE >= 2) ? SIZE - 2 : 0);

  state_t                                   state_q, state_d;
  logic                                     mode_q, mode_d;
  logic [CNT_W-1:0]                         cnt_q, cnt_d;
  // Per lane [lane][slot]; slot 0 is the newest entry.
  logic [SIZE-1:0][SIZE-1:0][DATA_SIZE-1:0] data_q, data_d;
  logic [SIZE-1:0][SIZE-1:0]                vld_q, vld_d;
  // Last-flag follows the maximum-delay lane, so only one chain is needed.
  logic [SIZE-1:0]                          last_q, last_d;

  logic accept;

  assign in_ready = en && (state_q != ST_DRAIN);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != ST_IDLE);

  // Next-state and counter
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    if (en) begin
      unique case (state_q)
        ST_IDLE, ST_STREAM: begin
          if (accept) begin
            if (state_q == ST_IDLE) begin
              mode_d = mode;
            end
            if (!in_last) begin
              state_d = ST_STREAM;
            end else if (SIZE == 1) begin
              // Nothing left in flight once the single tap has been loaded.
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DRAIN;
              cnt_d   = DRAIN_LOAD;
            end
          end
        end
        ST_DRAIN: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Lane shift registers; invalid slots always carry zero data.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    last_d = last_q;
    if (en) begin
      for (int j = 0; j < SIZE; j++) begin
        data_d[j][0] = accept ? in_row[(SIZE-j)*DATA_SIZE-1 -: DATA_SIZE] : '0;
        vld_d[j][0]  = accept;
        for (int k = 1; k < SIZE; k++) begin
          data_d[j][k] = data_q[j][k-1];
          vld_d[j][k]  = vld_q[j][k-1];
        end
      end
      last_d[0] = accept && in_last;
      for (int k = 1; k < SIZE; k++) begin
        last_d[k] = last_q[k-1];
      end
    end
  end

  // Output taps: lane j reads slot j (skew) or slot SIZE-1-j (deskew).
  always_comb begin
    out_row        = '0;
    out_lane_valid = '0;
    for (int j = 0; j < SIZE; j++) begin
      if (mode_q) begin
        out_row[(SIZE-j)*DATA_SIZE-1 -: DATA_SIZE] = data_q[j][SIZE-1-j];
        out_lane_valid[j]                          = vld_q[j][SIZE-1-j];
      end else begin
        out_row[(SIZE-j)*DATA_SIZE-1 -: DATA_SIZE] = data_q[j][j];
        out_lane_valid[j]                          = vld_q[j][j];
      end
    end
    out_last = last_q[SIZE-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      vld_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mult_matrix_skew.sv
module tb_mult_matrix_skew;

  localparam int DATA_SIZE = 4;
  localparam int SIZE      = 3;

  logic                      clk;
  logic                      rst_n;
  logic                      en;
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_last;
  logic                      mode;
  logic [DATA_SIZE*SIZE-1:0] in_row;
  logic [DATA_SIZE*SIZE-1:0] out_row;
  logic [SIZE-1:0]           out_lane_valid;
  logic                      out_last;
  logic                      busy;

  int checks;
  int failures;

  mult_matrix_skew #(.DATA_SIZE(DATA_SIZE), .SIZE(SIZE)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_last       (in_last),
    .mode          (mode),
    .in_row        (in_row),
    .out_row       (out_row),
    .out_lane_valid(out_lane_valid),
    .out_last      (out_last),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic l, input logic m, input logic [11:0] r);
    in_valid = v;
    in_last  = l;
    mode     = m;
    in_row   = r;
  endtask

  task automatic chk_out(input string tag, input logic [11:0] row, input logic [2:0] lv,
                         input logic last);
    chk({tag, "_row"}, 32'(out_row), 32'(row));
    chk({tag, "_lv"}, 32'(out_lane_valid), 32'(lv));
    chk({tag, "_last"}, 32'(out_last), 32'(last));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 12'h000);
    #12;
    // Reset state
    chk_out("rst", 12'h000, 3'b000, 1'b0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready_en0", 32'(in_ready), 32'd0);
    en = 1'b1;
    #1;
    chk("rst_ready_en1", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Skew, continuous, with drain handshake and back-to-back single-row frame
    drive(1'b1, 1'b0, 1'b0, 12'h123);
    tick();
    chk_out("sk_e0", 12'h100, 3'b001, 1'b0);
    chk("sk_e0_busy", 32'(busy), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 12'h456);
    tick();
    chk_out("sk_e1", 12'h420, 3'b011, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 12'h789);
    tick();
    chk_out("sk_e2", 12'h753, 3'b111, 1'b0);
    chk("sk_e2_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 12'hABC);
    tick();
    chk_out("sk_e3", 12'h086, 3'b110, 1'b0);
    chk("sk_e3_ready", 32'(in_ready), 32'd0);
    chk("sk_e3_busy", 32'(busy), 32'd1);
    tick();
    chk_out("sk_e4", 12'h009, 3'b100, 1'b1);
    chk("sk_e4_ready", 32'(in_ready), 32'd1);
    tick();
    chk_out("b2b_e5", 12'hA00, 3'b001, 1'b0);
    chk("b2b_e5_busy", 32'(busy), 32'd1);
    chk("b2b_e5_ready", 32'(in_ready), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 12'h000);
    tick();
    chk_out("b2b_e6", 12'h0B0, 3'b010, 1'b0);
    tick();
    chk_out("b2b_e7", 12'h00C, 3'b100, 1'b1);
    chk("b2b_e7_busy", 32'(busy), 32'd0);
    chk("b2b_e7_ready", 32'(in_ready), 32'd1);
    tick();
    chk_out("b2b_idle", 12'h000, 3'b000, 1'b0);

    // Deskew; mode toggled mid-frame must be ignored
    drive(1'b1, 1'b0, 1'b1, 12'h123);
    tick();
    chk_out("dk_e0", 12'h003, 3'b100, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 12'h456);
    tick();
    chk_out("dk_e1", 12'h026, 3'b110, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 12'h789);
    tick();
    chk_out("dk_e2", 12'h159, 3'b111, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 12'h000);
    tick();
    chk_out("dk_e3", 12'h480, 3'b011, 1'b0);
    tick();
    chk_out("dk_e4", 12'h700, 3'b001, 1'b1);
    chk("dk_e4_busy", 32'(busy), 32'd0);
    tick();

    // Bubble and stall, skew
    drive(1'b1, 1'b0, 1'b0, 12'h123);
    tick();
    chk_out("bs_e0", 12'h100, 3'b001, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 12'hFFF);
    tick();
    chk_out("bs_e1", 12'h020, 3'b010, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 12'h456);
    tick();
    chk_out("bs_e2", 12'h403, 3'b101, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 12'h789);
    en = 1'b0;
    #1;
    chk("bs_stall_ready", 32'(in_ready), 32'd0);
    tick();
    chk_out("bs_stall1", 12'h403, 3'b101, 1'b0);
    tick();
    chk_out("bs_stall2", 12'h403, 3'b101, 1'b0);
    chk("bs_stall2_busy", 32'(busy), 32'd1);
    en = 1'b1;
    tick();
    chk_out("bs_e3", 12'h750, 3'b011, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 12'h000);
    tick();
    chk_out("bs_e4", 12'h086, 3'b110, 1'b0);
    tick();
    chk_out("bs_e5", 12'h009, 3'b100, 1'b1);
    tick();

    // Reset mid-frame, then a clean deskew frame
    drive(1'b1, 1'b0, 1'b0, 12'h123);
    tick();
    chk_out("rm_e0", 12'h100, 3'b001, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 12'h456);
    tick();
    chk_out("rm_e1", 12'h420, 3'b011, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 12'h000);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rm_async", 12'h000, 3'b000, 1'b0);
    chk("rm_async_busy", 32'(busy), 32'd0);
    chk("rm_async_ready", 32'(in_ready), 32'd1);
    #3;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 12'h123);
    tick();
    chk_out("rm_dk_e0", 12'h003, 3'b100, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 12'h456);
    tick();
    chk_out("rm_dk_e1", 12'h026, 3'b110, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 12'h789);
    tick();
    chk_out("rm_dk_e2", 12'h159, 3'b111, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 12'h000);
    tick();
    chk_out("rm_dk_e3", 12'h480, 3'b011, 1'b0);
    tick();
    chk_out("rm_dk_e4", 12'h700, 3'b001, 1'b1);
    tick();

    // Single-row frame, skew
    drive(1'b1, 1'b1, 1'b0, 12'h123);
    tick();
    chk_out("sr_e0", 12'h100, 3'b001, 1'b0);
    chk("sr_e0_busy", 32'(busy), 32'd1);
    chk("sr_e0_ready", 32'(in_ready), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 12'h000);
    tick();
    chk_out("sr_e1", 12'h020, 3'b010, 1'b0);
    tick();
    chk_out("sr_e2", 12'h003, 3'b100, 1'b1);
    chk("sr_e2_busy", 32'(busy), 32'd0);
    tick();
    chk_out("sr_e3", 12'h000, 3'b000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
